// File: rtl/fcd_timer_bank.sv
// Multi-channel countdown timer bank: per-channel load/countdown/expiry with optional periodic reload.
// Build with FCD_AUTORELOAD_EN defined to enable the reload register and the reload port.
module fcd_timer_ch #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             dset,
    input  logic [WIDTH-1:0] dread_data,
    input  logic             enable,
    input  logic             reload,
    output logic [WIDTH-1:0] count,
    output logic             finished,
    output logic             zero,
    output logic             expire
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             expire_nxt;
    logic             reload_hit;

`ifdef FCD_AUTORELOAD_EN
    logic [WIDTH-1:0] reload_val, reload_val_nxt;

    assign reload_hit = reload && (reload_val != '0);
`else
    logic unused_reload;

    assign unused_reload = reload;
    assign reload_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            expire <= 1'b0;
`ifdef FCD_AUTORELOAD_EN
            reload_val <= '0;
`endif
        end else begin
            state  <= state_nxt;
            count  <= count_nxt;
            expire <= expire_nxt;
`ifdef FCD_AUTORELOAD_EN
            reload_val <= reload_val_nxt;
`endif
        end
    end

    // dset wins over enable in every state and never expires the channel
    always_comb begin
        state_nxt  = state;
        count_nxt  = count;
        expire_nxt = 1'b0;
`ifdef FCD_AUTORELOAD_EN
        reload_val_nxt = reload_val;
`endif
        if (dset) begin
            count_nxt = dread_data;
            state_nxt = (dread_data != '0) ? RUN : DONE;
`ifdef FCD_AUTORELOAD_EN
            reload_val_nxt = dread_data;
`endif
        end else begin
            case (state)
                RUN: begin
                    if (enable) begin
                        if (count == WIDTH'(1)) begin
                            expire_nxt = 1'b1;
                            if (reload_hit) begin
`ifdef FCD_AUTORELOAD_EN
                                count_nxt = reload_val;
`else
                                count_nxt = '0;
`endif
                            end else begin
                                count_nxt = '0;
                                state_nxt = DONE;
                            end
                        end else begin
                            count_nxt = count - WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        finished = (count <= WIDTH'(1));
        zero     = (count == '0);
    end
endmodule

module fcd_timer_bank #(
    parameter int WIDTH    = 5,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       dset,
    input  logic [WIDTH-1:0]          dread_data,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       reload,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       finished,
    output logic [CHANNELS-1:0]       zero,
    output logic [CHANNELS-1:0]       expire,
    output logic                      any_expire
);
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        fcd_timer_ch #(.WIDTH(WIDTH)) u_ch (
            .clk        (clk),
            .reset      (reset),
            .dset       (dset[i]),
            .dread_data (dread_data),
            .enable     (enable[i]),
            .reload     (reload[i]),
            .count      (count[i*WIDTH +: WIDTH]),
            .finished   (finished[i]),
            .zero       (zero[i]),
            .expire     (expire[i])
        );
    end

    assign any_expire = |expire;
endmodule

// File: tb/tb_fcd_timer_bank.sv
// Directed self-checking bench for fcd_timer_bank (WIDTH=5, CHANNELS=4).
module tb_fcd_timer_bank;
    localparam int W = 5;
    localparam int C = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic [C-1:0]   dset, enable, reload;
    logic [W-1:0]   dread_data;
    logic [C*W-1:0] count;
    logic [C-1:0]   finished, zero, expire;
    logic           any_expire;

    int nvec = 0;
    int nerr = 0;

    fcd_timer_bank #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .dset       (dset),
        .dread_data (dread_data),
        .enable     (enable),
        .reload     (reload),
        .count      (count),
        .finished   (finished),
        .zero       (zero),
        .expire     (expire),
        .any_expire (any_expire)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt(input int ch);
        return int'(count[ch*W +: W]);
    endfunction

    initial begin
        int exp_c, pulses, e;

        reset = 1'b1; dset = '0; enable = '0; reload = '0; dread_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_count", int'(count), 0);
        chk("rst_finished", int'(finished), 4'hf);
        chk("rst_zero", int'(zero), 4'hf);
        chk("rst_expire", int'(expire), 0);
        chk("rst_any", int'(any_expire), 0);
        enable = '1;
        tick();
        chk("idle_en_count", int'(count), 0);
        chk("idle_en_expire", int'(expire), 0);
        enable = '0;

        // channel 0: load 7, count down to expiry
        dset = 4'b0001; dread_data = 5'd7;
        tick();
        chk("c0_load", cnt(0), 7);
        chk("c0_load_fin", int'(finished[0]), 0);
        dset = '0; enable = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("c0_cnt%0d", k), cnt(0), 7 - k);
            chk($sformatf("c0_fin%0d", k), int'(finished[0]), (k >= 6) ? 1 : 0);
            chk($sformatf("c0_zero%0d", k), int'(zero[0]), (k == 7) ? 1 : 0);
            chk($sformatf("c0_exp%0d", k), int'(expire[0]), (k == 7) ? 1 : 0);
        end
        tick();
        chk("c0_hold", cnt(0), 0);
        chk("c0_noexp", int'(expire[0]), 0);
        enable = '0;

        // channel 1: load 3 with reload selected, enable held 12 edges
        reload = 4'b0010; dset = 4'b0010; dread_data = 5'd3;
        tick();
        chk("c1_load", cnt(1), 3);
        dset = '0; enable = 4'b0010;
        exp_c = 3; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            e = 0;
            if (exp_c == 1) begin
                e = 1;
`ifdef FCD_AUTORELOAD_EN
                exp_c = 3;
`else
                exp_c = 0;
`endif
            end else if (exp_c > 0) begin
                exp_c--;
            end
            tick();
            pulses += int'(expire[1]);
            chk($sformatf("c1_cnt%0d", k), cnt(1), exp_c);
            chk($sformatf("c1_exp%0d", k), int'(expire[1]), e);
            chk($sformatf("c1_any%0d", k), int'(any_expire), e);
        end
`ifdef FCD_AUTORELOAD_EN
        chk("c1_pulses", pulses, 4);
`else
        chk("c1_pulses", pulses, 1);
`endif
        enable = '0; reload = '0;

        // channel 2: reach 1, then dset+enable together
        dset = 4'b0100; dread_data = 5'd2;
        tick();
        dset = '0; enable = 4'b0100;
        tick();
        chk("c2_at1", cnt(2), 1);
        dset = 4'b0100; dread_data = 5'd5;
        tick();
        chk("c2_dset_pri", cnt(2), 5);
        chk("c2_noexp", int'(expire[2]), 0);
        dset = '0; enable = '0;

        // channel 3: load 0 goes straight to DONE
        dset = 4'b1000; dread_data = 5'd0;
        tick();
        chk("c3_cnt", cnt(3), 0);
        chk("c3_zero", int'(zero[3]), 1);
        chk("c3_exp", int'(expire[3]), 0);
        dset = '0; enable = 4'b1000;
        tick();
        chk("c3_done_cnt", cnt(3), 0);
        chk("c3_done_exp", int'(expire[3]), 0);

        // reset mid-count with channel 0 about to expire
        dset = 4'b0111; dread_data = 5'd9; enable = '0;
        tick();
        dset = 4'b0001; dread_data = 5'd1;
        tick();
        chk("pre_rst_c0", cnt(0), 1);
        chk("pre_rst_c1", cnt(1), 9);
        dset = '0; enable = 4'b0111; reset = 1'b1;
        tick();
        chk("rst_mid_count", int'(count), 0);
        chk("rst_mid_exp", int'(expire), 0);
        chk("rst_mid_zero", int'(zero), 4'hf);
        reset = 1'b0;
        tick();
        chk("post_rst_count", int'(count), 0);
        chk("post_rst_any", int'(any_expire), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
